// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory
// that returns registered read data one cycle after mem_re.
//
// Writes complete in the grant cycle. A read parks the arbiter in RD_WAIT
// for one cycle while the memory returns data, which is then steered to the
// port that issued the read. No request is ever latched: a port is granted
// only while its valid is high in an IDLE cycle.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin tie-break using a last_grant flop
//                   undefined -> fixed priority, port 0 wins ties
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | free to grant; writes finish here, reads move on to RD_WAIT
// RD_WAIT | memory returning read data for owner; no grants, no access

module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,

    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t state;
    logic   owner;      // port that issued the outstanding read

    logic   grant0;
    logic   grant1;
    logic   grant_we;   // write flag of the granted port
    logic   grant_rd;   // a read is being granted this cycle
    logic   in_idle;

`ifdef DMEM_ARB_RR_EN
    logic   last_grant; // port granted most recently; loses the next tie
`endif

    // Grants are only possible out of reset and in IDLE, so every output is
    // forced low while rst_n is asserted.
    assign in_idle = rst_n && (state == IDLE);

    // Pick at most one port to serve this cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (in_idle) begin
            if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_RR_EN
                grant0 = last_grant;
                grant1 = !last_grant;
`else
                grant0 = 1'b1;
`endif
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Steer the granted port onto the memory bus; idle bus is all zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        grant_we  = 1'b0;
        if (grant0) begin
            grant_we  = req0_we;
            mem_we    = req0_we;
            mem_re    = !req0_we;
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
        end else if (grant1) begin
            grant_we  = req1_we;
            mem_we    = req1_we;
            mem_re    = !req1_we;
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
        end
    end

    assign grant_rd = (grant0 || grant1) && !grant_we;

    // Sequencer: a granted read holds the bus for the one-cycle return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        state <= RD_WAIT;
                        owner <= grant1;
                    end
                end
                RD_WAIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Remember who won so the other port takes the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end
`endif

    // Route returning read data to the owner; data is zero when not valid.
    always_comb begin
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp0_rdata = '0;
        rsp1_rdata = '0;
        if (rst_n && (state == RD_WAIT)) begin
            if (owner) begin
                rsp1_valid = 1'b1;
                rsp1_rdata = mem_rdata;
            end else begin
                rsp0_valid = 1'b1;
                rsp0_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, directed corner sequences and a randomized
// run against a transaction-level model of the two-port arbiter. A 16-word
// memory stub answers mem_re one cycle later. Honors DMEM_ARB_RR_EN.

module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req0_we, req1_valid, req1_we;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory stub with registered read data
    logic [DATA_W-1:0] env_mem [0:15] = '{default: '0};
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr[3:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= env_mem[mem_addr[3:0]];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int                m_pend;   // port awaiting read data, -1 if none
    int                m_last;   // port granted most recently
    logic [DATA_W-1:0] m_rd;
    logic [DATA_W-1:0] m_mem [0:15] = '{default: '0};

    task automatic model_reset();
        m_pend = -1;
        m_last = 1;
        m_rd   = '0;
    endtask

    function automatic int pick();
        if (req0_valid && req1_valid) begin
`ifdef DMEM_ARB_RR_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic check_model(input string tag);
        logic e_r0, e_r1, e_we, e_re, e_s0, e_s1;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata, e_rd0, e_rd1;
        int g;
        e_r0 = 0; e_r1 = 0; e_we = 0; e_re = 0; e_s0 = 0; e_s1 = 0;
        e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
        if (rst_n) begin
            if (m_pend == 0) begin
                e_s0 = 1; e_rd0 = m_rd;
            end else if (m_pend == 1) begin
                e_s1 = 1; e_rd1 = m_rd;
            end else begin
                g = pick();
                if (g == 0) begin
                    e_r0 = 1; e_we = req0_we; e_re = !req0_we;
                    e_addr = req0_addr; e_wdata = req0_wdata;
                end else if (g == 1) begin
                    e_r1 = 1; e_we = req1_we; e_re = !req1_we;
                    e_addr = req1_addr; e_wdata = req1_wdata;
                end
            end
        end
        chk({tag, ".req0_ready"}, 64'(req0_ready), 64'(e_r0));
        chk({tag, ".req1_ready"}, 64'(req1_ready), 64'(e_r1));
        chk({tag, ".mem_we"},     64'(mem_we),     64'(e_we));
        chk({tag, ".mem_re"},     64'(mem_re),     64'(e_re));
        chk({tag, ".mem_addr"},   64'(mem_addr),   64'(e_addr));
        chk({tag, ".mem_wdata"},  64'(mem_wdata),  64'(e_wdata));
        chk({tag, ".rsp0_valid"}, 64'(rsp0_valid), 64'(e_s0));
        chk({tag, ".rsp1_valid"}, 64'(rsp1_valid), 64'(e_s1));
        chk({tag, ".rsp0_rdata"}, 64'(rsp0_rdata), 64'(e_rd0));
        chk({tag, ".rsp1_rdata"}, 64'(rsp1_rdata), 64'(e_rd1));
    endtask

    task automatic model_update();
        int g;
        if (!rst_n) begin
            model_reset();
        end else if (m_pend >= 0) begin
            m_pend = -1;
        end else begin
            g = pick();
            if (g >= 0) begin
                m_last = g;
                if (g == 0) begin
                    if (req0_we) m_mem[req0_addr[3:0]] = req0_wdata;
                    else begin m_pend = 0; m_rd = m_mem[req0_addr[3:0]]; end
                end else begin
                    if (req1_we) m_mem[req1_addr[3:0]] = req1_wdata;
                    else begin m_pend = 1; m_rd = m_mem[req1_addr[3:0]]; end
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v0, input logic we0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0,
                         input logic v1, input logic we1, input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d1);
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    endtask

    task automatic settle(input string tag);
        #1;
        check_model(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_reset();
        settle("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic v0, we0; logic [31:0] a0, d0;
        logic v1, we1; logic [31:0] a1, d1;
        logic r0, r1, mwe, mre; logic [31:0] maddr, mwdata;
        logic s0, s1; logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vecs [10];

    logic [5:0] g0_rd, g1_rd, s0_rd, s1_rd;
    logic [3:0] g0_wr, g1_wr;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        model_reset();

        //           v0 we0 a0 d0            v1 we1 a1 d1        r0 r1 we re addr wdata         s0 s1 rd0           rd1
        vecs[0] = '{1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0,        1, 0, 1, 0, 5, 32'hDEADBEEF,  0, 0, 0,            0};
        vecs[1] = '{0, 0, 0, 0,            1, 0, 5, 0,        0, 1, 0, 1, 5, 0,             0, 0, 0,            0};
        vecs[2] = '{1, 1, 3, 32'h1234,     0, 0, 0, 0,        0, 0, 0, 0, 0, 0,             0, 1, 0,            32'hDEADBEEF};
        vecs[3] = '{1, 1, 3, 32'h1234,     0, 0, 0, 0,        1, 0, 1, 0, 3, 32'h1234,      0, 0, 0,            0};
        vecs[4] = '{0, 0, 0, 0,            1, 0, 3, 0,        0, 1, 0, 1, 3, 0,             0, 0, 0,            0};
        vecs[5] = '{0, 0, 0, 0,            0, 0, 0, 0,        0, 0, 0, 0, 0, 0,             0, 1, 0,            32'h1234};
        vecs[6] = '{1, 0, 5, 0,            0, 0, 0, 0,        1, 0, 0, 1, 5, 0,             0, 0, 0,            0};
        vecs[7] = '{0, 0, 0, 0,            1, 1, 6, 32'hCAFE, 0, 0, 0, 0, 0, 0,             1, 0, 32'hDEADBEEF, 0};
        vecs[8] = '{0, 0, 0, 0,            1, 1, 6, 32'hCAFE, 0, 1, 1, 0, 6, 32'hCAFE,      0, 0, 0,            0};
        vecs[9] = '{0, 0, 0, 0,            0, 0, 0, 0,        0, 0, 0, 0, 0, 0,             0, 0, 0,            0};

`ifdef DMEM_ARB_RR_EN
        g0_rd = 6'b010001; g1_rd = 6'b000100; s0_rd = 6'b100010; s1_rd = 6'b001000;
        g0_wr = 4'b0101;   g1_wr = 4'b1010;
`else
        g0_rd = 6'b010101; g1_rd = 6'b000000; s0_rd = 6'b101010; s1_rd = 6'b000000;
        g0_wr = 4'b1111;   g1_wr = 4'b0000;
`endif

        // reset values, then single-requester vector table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
                  vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
            settle(t);
            chk({t, ".r0"},    64'(req0_ready), 64'(vecs[i].r0));
            chk({t, ".r1"},    64'(req1_ready), 64'(vecs[i].r1));
            chk({t, ".we"},    64'(mem_we),     64'(vecs[i].mwe));
            chk({t, ".re"},    64'(mem_re),     64'(vecs[i].mre));
            chk({t, ".addr"},  64'(mem_addr),   64'(vecs[i].maddr));
            chk({t, ".wdata"}, 64'(mem_wdata),  64'(vecs[i].mwdata));
            chk({t, ".s0"},    64'(rsp0_valid), 64'(vecs[i].s0));
            chk({t, ".s1"},    64'(rsp1_valid), 64'(vecs[i].s1));
            chk({t, ".rd0"},   64'(rsp0_rdata), 64'(vecs[i].rd0));
            chk({t, ".rd1"},   64'(rsp1_rdata), 64'(vecs[i].rd1));
            tick();
        end

        // reset pulsed while a read is outstanding
        drive(0, 0, 0, 0, 1, 0, 5, 0);
        settle("rstrd.grant");
        chk("rstrd.grant_re", 64'(mem_re), 64'(1));
        tick();
        drive(1, 1, 7, 32'hAA, 0, 0, 0, 0);
        #1;
        chk("rstrd.rsp_before", 64'(rsp1_valid), 64'(1));
        rst_n = 1'b0;
        model_reset();
        settle("rstrd.low");
        chk("rstrd.low_rsp1",  64'(rsp1_valid), 64'(0));
        chk("rstrd.low_ready", 64'(req0_ready), 64'(0));
        chk("rstrd.low_we",    64'(mem_we),     64'(0));
        tick();
        rst_n = 1'b1;
        settle("rstrd.first");
        chk("rstrd.first_ready", 64'(req0_ready), 64'(1));
        chk("rstrd.first_rsp1",  64'(rsp1_valid), 64'(0));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle("rstrd.after");
        chk("rstrd.after_rsp1", 64'(rsp1_valid), 64'(0));
        tick();

        // both ports reading for 6 cycles
        do_reset();
        drive(1, 0, 5, 0, 1, 0, 3, 0);
        for (int c = 0; c < 6; c++) begin
            string t;
            t = $sformatf("tierd%0d", c);
            settle(t);
            chk({t, ".g0"}, 64'(req0_ready), 64'(g0_rd[c]));
            chk({t, ".g1"}, 64'(req1_ready), 64'(g1_rd[c]));
            chk({t, ".s0"}, 64'(rsp0_valid), 64'(s0_rd[c]));
            chk({t, ".s1"}, 64'(rsp1_valid), 64'(s1_rd[c]));
            if (s0_rd[c]) chk({t, ".rd0"}, 64'(rsp0_rdata), 64'(32'hDEADBEEF));
            if (s1_rd[c]) chk({t, ".rd1"}, 64'(rsp1_rdata), 64'(32'h1234));
            tick();
        end

        // both ports writing for 4 cycles
        do_reset();
        drive(1, 1, 8, 32'h8888, 1, 1, 9, 32'h9999);
        for (int c = 0; c < 4; c++) begin
            string t;
            t = $sformatf("tiewr%0d", c);
            settle(t);
            chk({t, ".g0"}, 64'(req0_ready), 64'(g0_wr[c]));
            chk({t, ".g1"}, 64'(req1_ready), 64'(g1_wr[c]));
            chk({t, ".we"}, 64'(mem_we), 64'(1));
            chk({t, ".addr"}, 64'(mem_addr), g0_wr[c] ? 64'(8) : 64'(9));
            tick();
        end

        // port 0 valid only during RD_WAIT, dropped before it could be granted
        drive(0, 0, 0, 0, 1, 0, 9, 0);
        settle("drop.grant1");
        chk("drop.grant1_r1", 64'(req1_ready), 64'(1));
        tick();
        drive(1, 0, 4, 0, 0, 0, 0, 0);
        settle("drop.wait");
        chk("drop.wait_r0", 64'(req0_ready), 64'(0));
        chk("drop.wait_re", 64'(mem_re),     64'(0));
        chk("drop.wait_s1", 64'(rsp1_valid), 64'(1));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle("drop.idle");
        chk("drop.idle_r0", 64'(req0_ready), 64'(0));
        chk("drop.idle_we", 64'(mem_we),     64'(0));
        chk("drop.idle_re", 64'(mem_re),     64'(0));
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
            settle($sformatf("rand%0d", c));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
